// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and feeds
// {instruction, PC+4, valid} to IF/ID through a one-entry skid buffer.
module if_fetch_stage #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  keep_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [DATA_WIDTH-1:0] imem_data_i,
  output logic [DATA_WIDTH-1:0] ins_o,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic                  valid_o,
  output logic                  flush_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FULL,
    S_DISCARD
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] tgt_q;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [DATA_WIDTH-1:0] skid_ins;
  logic [ADDR_WIDTH-1:0] skid_addr;
  logic                  req_state;

  always_comb begin
    req_state   = (state == S_FETCH) || (state == S_DISCARD);
    pc_inc      = pc_q + ADDR_WIDTH'(4);
    imem_req_o  = req_state & ~rst_i;
    imem_addr_o = pc_q;
    flush_o     = ~valid_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      pc_q        <= RESET_VECTOR;
      tgt_q       <= '0;
      valid_o     <= 1'b0;
      ins_o       <= '0;
      next_addr_o <= '0;
      skid_ins    <= '0;
      skid_addr   <= '0;
    end else if (redirect_i) begin
      valid_o   <= 1'b0;
      skid_ins  <= '0;
      skid_addr <= '0;
      // An unacked request cannot be withdrawn: park the target until it completes.
      if (req_state && !imem_ack_i) begin
        tgt_q <= redirect_addr_i;
        state <= S_DISCARD;
      end else begin
        pc_q  <= redirect_addr_i;
        state <= S_FETCH;
      end
    end else begin
      if (!keep_i) valid_o <= 1'b0;
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (imem_ack_i) begin
            pc_q <= pc_inc;
            if (!keep_i || !valid_o) begin
              ins_o       <= imem_data_i;
              next_addr_o <= pc_inc;
              valid_o     <= 1'b1;
            end else begin
              skid_ins  <= imem_data_i;
              skid_addr <= pc_inc;
              state     <= S_FULL;
            end
          end
        end
        S_FULL: begin
          if (!keep_i) begin
            ins_o       <= skid_ins;
            next_addr_o <= skid_addr;
            valid_o     <= 1'b1;
            skid_ins    <= '0;
            skid_addr   <= '0;
            state       <= S_FETCH;
          end
        end
        S_DISCARD: begin
          if (imem_ack_i) begin
            pc_q  <= tgt_q;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized traffic against a
// queue-based model of the instructions held between memory and IF/ID.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        keep = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] raddr = '0;
  logic        ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic        imem_req_o, valid_o, flush_o;
  logic [31:0] imem_addr_o, ins_o, next_addr_o;

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .keep_i(keep), .redirect_i(redir),
    .redirect_addr_i(raddr), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(ack), .imem_data_i(mem_data), .ins_o(ins_o),
    .next_addr_o(next_addr_o), .valid_o(valid_o), .flush_o(flush_o)
  );

  always #5 clk = ~clk;

  // Reference: instructions fetched but not yet consumed, oldest first.
  typedef struct {
    logic [31:0] ins;
    logic [31:0] nxt;
  } item_t;
  item_t       m_q[$];
  logic [31:0] m_pc = '0;
  logic [31:0] m_tgt = '0;
  bit          m_idle = 1'b1;
  bit          m_disc = 1'b0;

  function automatic logic [31:0] fmem(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h13;
  endfunction

  function automatic bit m_req();
    return !rst && !m_idle && (m_q.size() < 2);
  endfunction

  // Present memory data, advance the model with the current inputs, then clock.
  task automatic tick();
    bit r;
    mem_data = fmem(imem_addr_o);
    r = m_req();
    if (rst) begin
      m_q.delete();
      m_pc = 32'h0; m_idle = 1'b1; m_disc = 1'b0;
    end else begin
      m_idle = 1'b0;
      if (redir) begin
        m_q.delete();
        if (r && !ack) begin m_disc = 1'b1; m_tgt = raddr; end
        else begin m_disc = 1'b0; m_pc = raddr; end
      end else begin
        if (!keep && m_q.size() > 0) void'(m_q.pop_front());
        if (r && ack) begin
          if (m_disc) begin m_pc = m_tgt; m_disc = 1'b0; end
          else begin m_q.push_back('{fmem(m_pc), m_pc + 32'd4}); m_pc = m_pc + 32'd4; end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; keep = 1'b0; redir = 1'b0; ack = 1'b1;
    tick(); tick();
    n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b exp 0", imem_req_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b exp 0", valid_o); end
    n_cmp++; if (ins_o !== 32'h0) begin n_bad++; $display("FAIL reset_ins: got %h exp 0", ins_o); end
    n_cmp++; if (next_addr_o !== 32'h0) begin n_bad++; $display("FAIL reset_next: got %h exp 0", next_addr_o); end
    n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL reset_flush: got %b exp 1", flush_o); end
    rst = 1'b0; ack = 1'b0;
    #1;
    n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL idle_req: got %b exp 0", imem_req_o); end
    tick();
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_bad++; $display("FAIL first_req: got req=%b addr=%h exp req=1 addr=0", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_zero_wait();
    ack = 1'b1; keep = 1'b0;
    n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL zw_flush: got %b exp 1", flush_o); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (valid_o !== 1'b1 || ins_o !== fmem(32'(4 * k)) || next_addr_o !== 32'(4 * k + 4)) begin
        n_bad++;
        $display("FAIL zw_seq%0d: got v=%b ins=%h nxt=%h exp v=1 ins=%h nxt=%h",
                 k, valid_o, ins_o, next_addr_o, fmem(32'(4 * k)), 32'(4 * k + 4));
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] a0;
    int pulses = 0;
    keep = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ack = (i % 3 == 2);
      a0 = imem_addr_o;
      tick();
      if (i % 3 != 2) begin
        n_cmp++; if (imem_addr_o !== a0 || imem_req_o !== 1'b1) begin
          n_bad++; $display("FAIL ws_addr%0d: got req=%b addr=%h exp req=1 addr=%h", i, imem_req_o, imem_addr_o, a0);
        end
      end else begin
        n_cmp++; if (valid_o !== 1'b1 || ins_o !== fmem(a0)) begin
          n_bad++; $display("FAIL ws_data%0d: got v=%b ins=%h exp v=1 ins=%h", i, valid_o, ins_o, fmem(a0));
        end
      end
      if (valid_o) pulses++;
    end
    n_cmp++; if (pulses != 3) begin n_bad++; $display("FAIL ws_pulses: got %0d exp 3", pulses); end
  endtask

  task automatic test_skid();
    logic [31:0] held, p;
    held = ins_o; p = imem_addr_o;
    keep = 1'b1; ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (imem_req_o !== 1'b0 || ins_o !== held || valid_o !== 1'b1) begin
        n_bad++; $display("FAIL skid_hold%0d: got req=%b v=%b ins=%h exp req=0 v=1 ins=%h", i, imem_req_o, valid_o, ins_o, held);
      end
    end
    keep = 1'b0;
    tick();
    n_cmp++; if (valid_o !== 1'b1 || ins_o !== fmem(p) || next_addr_o !== p + 32'd4) begin
      n_bad++; $display("FAIL skid_out: got v=%b ins=%h nxt=%h exp ins=%h nxt=%h", valid_o, ins_o, next_addr_o, fmem(p), p + 32'd4);
    end
    tick();
    n_cmp++; if (valid_o !== 1'b1 || ins_o !== fmem(p + 32'd4)) begin
      n_bad++; $display("FAIL skid_resume: got v=%b ins=%h exp ins=%h", valid_o, ins_o, fmem(p + 32'd4));
    end
  endtask

  task automatic test_redirect_inflight();
    keep = 1'b0; ack = 1'b1; redir = 1'b1; raddr = 32'h20;
    tick();
    redir = 1'b0; ack = 1'b0;
    tick();
    redir = 1'b1; raddr = 32'h100;
    tick();
    redir = 1'b0;
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h20 || valid_o !== 1'b0) begin
      n_bad++; $display("FAIL rdf_hold: got req=%b addr=%h v=%b exp req=1 addr=20 v=0", imem_req_o, imem_addr_o, valid_o);
    end
    ack = 1'b1;
    tick();
    n_cmp++; if (valid_o !== 1'b0 || imem_addr_o !== 32'h100 || imem_req_o !== 1'b1) begin
      n_bad++; $display("FAIL rdf_drop: got v=%b addr=%h req=%b exp v=0 addr=100 req=1", valid_o, imem_addr_o, imem_req_o);
    end
    tick();
    n_cmp++; if (valid_o !== 1'b1 || ins_o !== fmem(32'h100) || next_addr_o !== 32'h104) begin
      n_bad++; $display("FAIL rdf_new: got v=%b ins=%h nxt=%h exp ins=%h nxt=104", valid_o, ins_o, next_addr_o, fmem(32'h100));
    end
  endtask

  task automatic test_redirect_ack_keep();
    keep = 1'b1; ack = 1'b1; redir = 1'b1; raddr = 32'h40;
    tick();
    redir = 1'b0; ack = 1'b0; keep = 1'b0;
    n_cmp++; if (valid_o !== 1'b0 || imem_addr_o !== 32'h40 || imem_req_o !== 1'b1) begin
      n_bad++; $display("FAIL rak: got v=%b addr=%h req=%b exp v=0 addr=40 req=1", valid_o, imem_addr_o, imem_req_o);
    end
  endtask

  task automatic test_wrap();
    ack = 1'b1; keep = 1'b0; redir = 1'b1; raddr = 32'hFFFF_FFFC;
    tick();
    redir = 1'b0;
    tick();
    n_cmp++; if (valid_o !== 1'b1 || ins_o !== fmem(32'hFFFF_FFFC) || next_addr_o !== 32'h0 || imem_addr_o !== 32'h0) begin
      n_bad++; $display("FAIL wrap: got v=%b ins=%h nxt=%h addr=%h exp nxt=0 addr=0", valid_o, ins_o, next_addr_o, imem_addr_o);
    end
  endtask

  task automatic test_reset_midwait();
    ack = 1'b0;
    tick();
    rst = 1'b1; ack = 1'b1; keep = 1'b1;
    tick();
    n_cmp++; if (imem_req_o !== 1'b0 || valid_o !== 1'b0 || ins_o !== 32'h0 || next_addr_o !== 32'h0 || imem_addr_o !== 32'h0) begin
      n_bad++; $display("FAIL rst_mid: got req=%b v=%b ins=%h nxt=%h addr=%h exp all 0", imem_req_o, valid_o, ins_o, next_addr_o, imem_addr_o);
    end
    rst = 1'b0; keep = 1'b0; ack = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      keep  = ($urandom_range(0, 1) == 1);
      ack   = ($urandom_range(0, 9) < 6);
      redir = ($urandom_range(0, 19) == 0);
      raddr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      tick();
      n_cmp++; if (imem_req_o !== m_req()) begin
        n_bad++; $display("FAIL rnd_req%0d: got %b exp %b", i, imem_req_o, m_req());
      end
      if (m_req()) begin
        n_cmp++; if (imem_addr_o !== m_pc) begin
          n_bad++; $display("FAIL rnd_addr%0d: got %h exp %h", i, imem_addr_o, m_pc);
        end
      end
      n_cmp++; if (valid_o !== (m_q.size() > 0) || flush_o !== (m_q.size() == 0)) begin
        n_bad++; $display("FAIL rnd_valid%0d: got v=%b f=%b exp v=%b", i, valid_o, flush_o, m_q.size() > 0);
      end
      if (m_q.size() > 0) begin
        n_cmp++; if (ins_o !== m_q[0].ins || next_addr_o !== m_q[0].nxt) begin
          n_bad++; $display("FAIL rnd_out%0d: got ins=%h nxt=%h exp ins=%h nxt=%h", i, ins_o, next_addr_o, m_q[0].ins, m_q[0].nxt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_skid();
    test_redirect_inflight();
    test_redirect_ack_keep();
    test_wrap();
    test_reset_midwait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
